// File: rtl/adder_result_buffer.sv
// Result buffer behind the 64-bit adder: a 2-entry skid FIFO of {sum, flags}
// with a saturating count of accepted overflow results.
module adder_result_buffer #(
  parameter int WIDTH = 64,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  input  logic             count_clr,
  output logic [CW-1:0]    ovf_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] r_sum [2];
  logic [1:0]       r_zero;
  logic [1:0]       r_neg;
  logic [1:0]       r_ovf;
  logic             r_wptr;
  logic             r_rptr;
  logic [CW-1:0]    r_cnt;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: if (w_push) w_next = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_next = S_FULL;
        else if (w_pop && !w_push) w_next = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
  end

  // Handshake outputs decode registered state only.
  always_comb begin
    in_ready  = (r_state != S_FULL);
    out_valid = (r_state != S_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum[0] <= '0;
      r_sum[1] <= '0;
      r_zero   <= '0;
      r_neg    <= '0;
      r_ovf    <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_sum[r_wptr]  <= in_sum;
        r_zero[r_wptr] <= (in_sum == '0);
        r_neg[r_wptr]  <= in_sum[WIDTH-1];
        r_ovf[r_wptr]  <= in_overflow;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  assign out_result = r_sum[r_rptr];
  assign out_zero   = r_zero[r_rptr];
  assign out_neg    = r_neg[r_rptr];
  assign out_ovf    = r_ovf[r_rptr];

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (count_clr) begin
      r_cnt <= '0;
    end else if (w_push && in_overflow &&
                 (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ovf_count = r_cnt;

endmodule
